ct_ifu_sfp_updt_ctrl: RTL and testbench
=======================================

Name: ct_ifu_sfp_updt_ctrl

Overview:
- Update sequencer for the IFU SFP predictor table, an array of ENTRY_NUM SFP entries.
- Arbitrates between two requesters: allocation of a new sf/bar PC pair, and counter training of an existing entry.
- Selects the victim entry on allocation.
- Drives the shared per-entry write bus: one-hot write and clock-enable vectors, update-select bits, and 25-bit write data.
- The sf PC and bar PC share write-data field [15:4], so an allocation is sequenced as two back-to-back writes.

Parameters:
- ENTRY_NUM, 8, number of SFP entries driven.
- PTR_W, 3, round-robin pointer width; must equal log2(ENTRY_NUM).

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  synchronous active-low reset.
- cp0_ifu_nsfe  in  1  SFP enable (CP0).
- sfp_vl_pred_en  in  1  SFP enable (vector-load prediction).
- alloc_vld  in  1  allocation request.
- alloc_rdy  out  1  allocation accepted when alloc_vld && alloc_rdy.
- alloc_type  in  1  entry type.
- alloc_hi_pc  in  8  high PC bits.
- alloc_sf_pc  in  12  sf PC.
- alloc_bar_pc  in  12  bar PC.
- train_vld  in  1  training request.
- train_rdy  out  1  training accepted when train_vld && train_rdy.
- train_hit_idx  in  ENTRY_NUM  one-hot target entry.
- train_op  in  4  one-hot counter op: 1000 clear, 0100 inc, 0010 set1, 0001 dec.
- train_type  in  1  type qualifier for the op.
- entry_cnt_all  in  2*ENTRY_NUM  concatenated entry counters; entry i at bits [2i+1:2i].
- entry_clk_en_x  out  ENTRY_NUM  per-entry clock enable.
- entry_write_en_x  out  ENTRY_NUM  per-entry write enable.
- entry_sf_pc_updt_bit  out  1  select sf/hi/type update.
- entry_bar_pc_updt_bit  out  1  select bar update.
- entry_cnt_updt_bit  out  1  select counter update.
- entry_write_data  out  25  [24] type, [23:16] hi, [15:4] pc, [3:0] cnt op.
- sfp_ctrl_busy  out  1  state != IDLE.

Behaviour:
- Reset: synchronous on cpurst_b low at a forever_cpuclk edge. Clears state to IDLE, rr_ptr to 0, and all latched request registers.
- Reset outputs: all outputs 0 (rdy outputs 0 during reset). Reset mid-sequence abandons the write and emits no further enables.
- sfp_en = cp0_ifu_nsfe || sfp_vl_pred_en.
- States: IDLE, WR_SF, WR_BAR, WR_CNT.
- Ready: train_rdy = (state==IDLE) && sfp_en. alloc_rdy = train_rdy && !train_vld, i.e. training has fixed priority.
- IDLE -> WR_CNT on train accept. Latches train_hit_idx, train_op and train_type.
- IDLE -> WR_SF on alloc accept. Latches type, hi, sf and bar PCs, and the victim one-hot.
- WR_SF -> WR_BAR unconditionally.
- WR_BAR -> IDLE and WR_CNT -> IDLE unconditionally. No request is accepted in WR_*.
- Latency: train accepted at T writes at T+1, and rdy returns at T+2. Alloc accepted at T writes sf at T+1 and bar at T+2, and rdy returns at T+3.
- Victim selection, evaluated in the accept cycle:
  - lowest index i with entry_cnt_all[2i+1:2i]==0; otherwise entry rr_ptr.
  - rr_ptr increments, wrapping ENTRY_NUM-1 -> 0, only when the rr_ptr entry is used.
- Outputs are combinational from state and the latched registers.
  - IDLE: enables, updt bits and data are all 0.
  - WR_SF: write_en = clk_en = victim; sf_updt=1, cnt_updt=1; data = {type, hi, sf_pc, 4'b0010}.
  - WR_BAR: write_en = clk_en = victim; bar_updt=1; data = {type, hi, bar_pc, 4'b0000}.
  - WR_CNT: write_en = clk_en = latched idx; cnt_updt=1; data = {train_type, 8'b0, 12'b0, op}.
- Boundary conditions:
  - train_hit_idx == 0 is accepted, and WR_CNT drives zero enables (a silent drop).
  - Non-one-hot train_op is passed through unchanged; the entry treats it as clear.
  - sfp_en dropping mid-sequence does not stall the FSM, and the write still issues; the entries gate it themselves.
  - Simultaneous alloc_vld and train_vld: train is accepted first, and alloc is accepted no earlier than T+2.

Test Plan:
- Reset then idle: all outputs 0, rr_ptr=0. Raise cp0_ifu_nsfe: train_rdy=1, alloc_rdy=1.
- Alloc with all counters nonzero (type=1, hi=0xA5, sf=0x123, bar=0x456), accepted at T:
  - T+1: write_en=0x01, data=0x1A51232, sf_updt=1, cnt_updt=1.
  - T+2: write_en=0x01, data=0x1A54560, bar_updt=1.
  - T+3: rr_ptr=1, alloc_rdy=1.
- entry_cnt_all with entry 5 only at 0, then alloc: victim 0x20 in both write cycles, rr_ptr unchanged.
- Train idx=0x08, op=0100, train_type=0: one cycle later write_en=0x08, cnt_updt=1, data[3:0]=0100, other fields 0. train_rdy low for exactly 1 cycle.
- Simultaneous train and alloc vld: train accepted first (WR_CNT), alloc accepted 2 cycles later. Nine consecutive rr-path allocs: rr_ptr wraps 7 -> 0.
- Both enables low: neither rdy asserts. Reset asserted during WR_SF: next cycle IDLE, no WR_BAR enable.

Source files
------------

// File: rtl/ct_ifu_sfp_updt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_ifu_sfp_updt_ctrl
// Description : Update sequencer for the IFU SFP predictor table.
//               Arbitrates between allocation of a new sf/bar PC pair and
//               counter training of an existing entry. It also picks the
//               victim entry on allocation and drives the shared per-entry
//               write bus. The sf PC and bar PC share write-data field
//               [15:4], so an allocation takes two back-to-back writes.
// Ports       : forever_cpuclk / cpurst_b      clock, sync active-low reset
//               cp0_ifu_nsfe, sfp_vl_pred_en   SFP enables (OR-ed)
//               alloc_*                        allocation request/handshake
//               train_*                        training request/handshake
//               entry_cnt_all                  2-bit counter per entry
//               entry_clk_en_x/_write_en_x     one-hot per-entry enables
//               entry_*_updt_bit               field update selects
//               entry_write_data               {type,hi[7:0],pc[11:0],op[3:0]}
//               sfp_ctrl_busy                  sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ct_ifu_sfp_updt_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int PTR_W     = 3
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   cp0_ifu_nsfe,
    input  logic                   sfp_vl_pred_en,
    input  logic                   alloc_vld,
    output logic                   alloc_rdy,
    input  logic                   alloc_type,
    input  logic [7:0]             alloc_hi_pc,
    input  logic [11:0]            alloc_sf_pc,
    input  logic [11:0]            alloc_bar_pc,
    input  logic                   train_vld,
    output logic                   train_rdy,
    input  logic [ENTRY_NUM-1:0]   train_hit_idx,
    input  logic [3:0]             train_op,
    input  logic                   train_type,
    input  logic [2*ENTRY_NUM-1:0] entry_cnt_all,
    output logic [ENTRY_NUM-1:0]   entry_clk_en_x,
    output logic [ENTRY_NUM-1:0]   entry_write_en_x,
    output logic                   entry_sf_pc_updt_bit,
    output logic                   entry_bar_pc_updt_bit,
    output logic                   entry_cnt_updt_bit,
    output logic [24:0]            entry_write_data,
    output logic                   sfp_ctrl_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_SF  = 2'd1,
        WR_BAR = 2'd2,
        WR_CNT = 2'd3
    } state_t;

    localparam logic [3:0]           c_OP_SF_INIT = 4'b0010;
    localparam logic [PTR_W-1:0]     c_PTR_LAST   = PTR_W'(ENTRY_NUM - 1);
    localparam logic [ENTRY_NUM-1:0] c_ONE        = ENTRY_NUM'(1);

    state_t                 r_state;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic                   r_alloc_type;
    logic [7:0]             r_alloc_hi_pc;
    logic [11:0]            r_alloc_sf_pc;
    logic [11:0]            r_alloc_bar_pc;
    logic [ENTRY_NUM-1:0]   r_victim_oh;
    logic [ENTRY_NUM-1:0]   r_train_idx;
    logic [3:0]             r_train_op;
    logic                   r_train_type;

    logic                   w_sfp_en;
    logic                   w_train_acc;
    logic                   w_alloc_acc;
    logic                   w_zero_found;
    logic [PTR_W-1:0]       w_zero_idx;
    logic [PTR_W-1:0]       w_victim_idx;
    logic [ENTRY_NUM-1:0]   w_victim_oh;

    assign w_sfp_en = cp0_ifu_nsfe | sfp_vl_pred_en;

    // Handshakes are held low while reset is asserted, even before the
    // first reset edge has cleared the state register.
    assign train_rdy   = cpurst_b & (r_state == IDLE) & w_sfp_en;
    assign alloc_rdy   = train_rdy & ~train_vld;
    assign w_train_acc = train_vld & train_rdy;
    assign w_alloc_acc = alloc_vld & alloc_rdy;

    // Lowest-index entry with a zero counter. Scanning from the top down
    // lets the lowest match overwrite any higher one.
    always_comb begin
        w_zero_found = 1'b0;
        w_zero_idx   = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (entry_cnt_all[2*i +: 2] == 2'b00) begin
                w_zero_found = 1'b1;
                w_zero_idx   = PTR_W'(i);
            end
        end
    end

    assign w_victim_idx = w_zero_found ? w_zero_idx : r_rr_ptr;
    assign w_victim_oh  = c_ONE << w_victim_idx;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_alloc_type   <= 1'b0;
            r_alloc_hi_pc  <= '0;
            r_alloc_sf_pc  <= '0;
            r_alloc_bar_pc <= '0;
            r_victim_oh    <= '0;
            r_train_idx    <= '0;
            r_train_op     <= '0;
            r_train_type   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_train_acc) begin
                        r_state      <= WR_CNT;
                        r_train_idx  <= train_hit_idx;
                        r_train_op   <= train_op;
                        r_train_type <= train_type;
                    end else if (w_alloc_acc) begin
                        r_state        <= WR_SF;
                        r_alloc_type   <= alloc_type;
                        r_alloc_hi_pc  <= alloc_hi_pc;
                        r_alloc_sf_pc  <= alloc_sf_pc;
                        r_alloc_bar_pc <= alloc_bar_pc;
                        r_victim_oh    <= w_victim_oh;
                        // The pointer only moves past the entry it names
                        // once that entry has actually been taken.
                        if (w_victim_idx == r_rr_ptr) begin
                            r_rr_ptr <= (r_rr_ptr == c_PTR_LAST) ? '0
                                                                 : r_rr_ptr + 1'b1;
                        end
                    end
                end
                WR_SF:   r_state <= WR_BAR;
                WR_BAR:  r_state <= IDLE;
                WR_CNT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        entry_write_en_x      = '0;
        entry_sf_pc_updt_bit  = 1'b0;
        entry_bar_pc_updt_bit = 1'b0;
        entry_cnt_updt_bit    = 1'b0;
        entry_write_data      = '0;
        case (r_state)
            WR_SF: begin
                // First allocation write also seeds the counter.
                entry_write_en_x     = r_victim_oh;
                entry_sf_pc_updt_bit = 1'b1;
                entry_cnt_updt_bit   = 1'b1;
                entry_write_data     = {r_alloc_type, r_alloc_hi_pc,
                                        r_alloc_sf_pc, c_OP_SF_INIT};
            end
            WR_BAR: begin
                entry_write_en_x      = r_victim_oh;
                entry_bar_pc_updt_bit = 1'b1;
                entry_write_data      = {r_alloc_type, r_alloc_hi_pc,
                                         r_alloc_bar_pc, 4'b0000};
            end
            WR_CNT: begin
                // Index and op pass through untouched; a zero index is a
                // silent drop and odd ops are resolved by the entries.
                entry_write_en_x   = r_train_idx;
                entry_cnt_updt_bit = 1'b1;
                entry_write_data   = {r_train_type, 20'b0, r_train_op};
            end
            default: ;
        endcase
    end

    assign entry_clk_en_x = entry_write_en_x;
    assign sfp_ctrl_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ct_ifu_sfp_updt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_ifu_sfp_updt_ctrl
// Description : Self-checking bench for ct_ifu_sfp_updt_ctrl. A queue of
//               pending entry writes models the sequencer; an empty queue
//               means idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_ifu_sfp_updt_ctrl;

    localparam int ENTRY_NUM = 8;
    localparam int PTR_W     = 3;

    logic                   forever_cpuclk = 1'b0;
    logic                   cpurst_b = 1'b0;
    logic                   cp0_ifu_nsfe = 1'b0;
    logic                   sfp_vl_pred_en = 1'b0;
    logic                   alloc_vld = 1'b0;
    logic                   alloc_rdy;
    logic                   alloc_type = 1'b0;
    logic [7:0]             alloc_hi_pc = '0;
    logic [11:0]            alloc_sf_pc = '0;
    logic [11:0]            alloc_bar_pc = '0;
    logic                   train_vld = 1'b0;
    logic                   train_rdy;
    logic [ENTRY_NUM-1:0]   train_hit_idx = '0;
    logic [3:0]             train_op = '0;
    logic                   train_type = 1'b0;
    logic [2*ENTRY_NUM-1:0] entry_cnt_all = 16'h5555;
    logic [ENTRY_NUM-1:0]   entry_clk_en_x;
    logic [ENTRY_NUM-1:0]   entry_write_en_x;
    logic                   entry_sf_pc_updt_bit;
    logic                   entry_bar_pc_updt_bit;
    logic                   entry_cnt_updt_bit;
    logic [24:0]            entry_write_data;
    logic                   sfp_ctrl_busy;

    ct_ifu_sfp_updt_ctrl #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W)) dut (
        .forever_cpuclk       (forever_cpuclk),
        .cpurst_b             (cpurst_b),
        .cp0_ifu_nsfe         (cp0_ifu_nsfe),
        .sfp_vl_pred_en       (sfp_vl_pred_en),
        .alloc_vld            (alloc_vld),
        .alloc_rdy            (alloc_rdy),
        .alloc_type           (alloc_type),
        .alloc_hi_pc          (alloc_hi_pc),
        .alloc_sf_pc          (alloc_sf_pc),
        .alloc_bar_pc         (alloc_bar_pc),
        .train_vld            (train_vld),
        .train_rdy            (train_rdy),
        .train_hit_idx        (train_hit_idx),
        .train_op             (train_op),
        .train_type           (train_type),
        .entry_cnt_all        (entry_cnt_all),
        .entry_clk_en_x       (entry_clk_en_x),
        .entry_write_en_x     (entry_write_en_x),
        .entry_sf_pc_updt_bit (entry_sf_pc_updt_bit),
        .entry_bar_pc_updt_bit(entry_bar_pc_updt_bit),
        .entry_cnt_updt_bit   (entry_cnt_updt_bit),
        .entry_write_data     (entry_write_data),
        .sfp_ctrl_busy        (sfp_ctrl_busy)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // One pending write on the entry bus.
    typedef struct packed {
        logic [7:0]  en;
        logic        sf;
        logic        bar;
        logic        cnt;
        logic [24:0] data;
    } wr_t;

    wr_t q[$];
    int  m_rr = 0;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the head of the pending-write queue.
    task automatic check_outputs();
        wr_t h;
        logic en_ok, trdy, ardy;
        h    = (q.size() != 0) ? q[0] : '0;
        en_ok = cp0_ifu_nsfe || sfp_vl_pred_en;
        trdy = cpurst_b && (q.size() == 0) && en_ok;
        ardy = trdy && !train_vld;
        chk("write_en",  {24'b0, entry_write_en_x}, {24'b0, h.en});
        chk("clk_en",    {24'b0, entry_clk_en_x},   {24'b0, h.en});
        chk("sf_updt",   {31'b0, entry_sf_pc_updt_bit},  {31'b0, h.sf});
        chk("bar_updt",  {31'b0, entry_bar_pc_updt_bit}, {31'b0, h.bar});
        chk("cnt_updt",  {31'b0, entry_cnt_updt_bit},    {31'b0, h.cnt});
        chk("data",      {7'b0, entry_write_data},       {7'b0, h.data});
        chk("busy",      {31'b0, sfp_ctrl_busy},         {31'b0, (q.size() != 0)});
        chk("train_rdy", {31'b0, train_rdy}, {31'b0, trdy});
        chk("alloc_rdy", {31'b0, alloc_rdy}, {31'b0, ardy});
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic model_edge();
        wr_t w;
        int  v;
        if (!cpurst_b) begin
            q.delete();
            m_rr = 0;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (cp0_ifu_nsfe || sfp_vl_pred_en) begin
            if (train_vld) begin
                w.en = train_hit_idx; w.sf = 0; w.bar = 0; w.cnt = 1;
                w.data = 25'((32'(train_type) << 24) | 32'(train_op));
                q.push_back(w);
            end else if (alloc_vld) begin
                v = m_rr;
                for (int i = ENTRY_NUM - 1; i >= 0; i--)
                    if (((entry_cnt_all >> (2 * i)) & 16'h3) == 0) v = i;
                w.en = 8'(1 << v); w.sf = 1; w.bar = 0; w.cnt = 1;
                w.data = 25'((32'(alloc_type) << 24) | (32'(alloc_hi_pc) << 16)
                             | (32'(alloc_sf_pc) << 4) | 2);
                q.push_back(w);
                w.sf = 0; w.bar = 1; w.cnt = 0;
                w.data = 25'((32'(alloc_type) << 24) | (32'(alloc_hi_pc) << 16)
                             | (32'(alloc_bar_pc) << 4));
                q.push_back(w);
                if (v == m_rr) m_rr = (m_rr + 1) % ENTRY_NUM;
            end
        end
    endtask

    // Inputs are set just after an edge; checks land 1 ns later.
    task automatic cycle();
        #1 check_outputs();
        @(posedge forever_cpuclk);
        model_edge();
        #1;
    endtask

    task automatic set_alloc(input logic t, input logic [7:0] hi,
                             input logic [11:0] sf, input logic [11:0] bar);
        alloc_vld = 1'b1; alloc_type = t; alloc_hi_pc = hi;
        alloc_sf_pc = sf; alloc_bar_pc = bar;
    endtask

    initial begin
        // Reset: first edge clears state, then check the reset cycle.
        @(posedge forever_cpuclk); model_edge(); #1;
        cycle();
        cpurst_b = 1'b1;
        cycle();                                   // enables low: no rdy
        chk("rdy_off", {30'b0, train_rdy, alloc_rdy}, 32'h0);
        cp0_ifu_nsfe = 1'b1;
        #1 chk("rdy_on", {30'b0, train_rdy, alloc_rdy}, 32'h3);
        cycle();

        // Alloc, all counters nonzero: round-robin victim entry 0.
        entry_cnt_all = 16'h5555;
        set_alloc(1'b1, 8'hA5, 12'h123, 12'h456);
        cycle();
        alloc_vld = 1'b0;
        #1 chk("sf_data_const", {7'b0, entry_write_data}, 32'h1A51232);
        chk("sf_en_const", {24'b0, entry_write_en_x}, 32'h01);
        cycle();
        chk("bar_data_const", {7'b0, entry_write_data}, 32'h1A54560);
        cycle();
        chk("rdy_back", {31'b0, alloc_rdy}, 32'h1);

        // Entry 5 counter zero: victim 0x20, pointer stays at 1.
        entry_cnt_all = 16'hF3FF;
        set_alloc(1'b0, 8'h3C, 12'hABC, 12'hDEF);
        cycle();
        alloc_vld = 1'b0; entry_cnt_all = 16'h5555;
        #1 chk("zero_victim", {24'b0, entry_write_en_x}, 32'h20);
        cycle(); cycle();
        set_alloc(1'b0, 8'h01, 12'h001, 12'h002);  // rr path -> entry 1
        cycle();
        alloc_vld = 1'b0;
        #1 chk("rr_after_zero", {24'b0, entry_write_en_x}, 32'h02);
        cycle(); cycle();

        // Training: idx 0x08, inc op, rdy low one cycle only.
        train_vld = 1'b1; train_hit_idx = 8'h08; train_op = 4'b0100; train_type = 1'b0;
        cycle();
        train_vld = 1'b0;
        #1 chk("train_data", {7'b0, entry_write_data}, 32'h4);
        chk("train_rdy_low", {31'b0, train_rdy}, 32'h0);
        cycle();
        chk("train_rdy_back", {31'b0, train_rdy}, 32'h1);

        // Simultaneous requests: train first, alloc once train drops.
        train_vld = 1'b1; train_hit_idx = 8'h80; train_op = 4'b0001;
        set_alloc(1'b1, 8'h11, 12'h222, 12'h333);
        cycle();
        train_vld = 1'b0;
        #1 chk("prio_cnt", {31'b0, entry_cnt_updt_bit}, 32'h1);
        cycle();                                   // alloc accepted at T+2
        alloc_vld = 1'b0;
        cycle(); cycle();

        // Nine round-robin allocs; pointer wraps 7 -> 0.
        for (int k = 0; k < 9; k++) begin
            set_alloc(k[0], 8'(k), 12'(k * 3), 12'(k * 5));
            cycle();
            alloc_vld = 1'b0;
            cycle(); cycle();
        end

        // Zero index (silent drop) with a non-one-hot op.
        train_vld = 1'b1; train_hit_idx = 8'h00; train_op = 4'b1010; train_type = 1'b1;
        cycle();
        train_vld = 1'b0;
        #1 chk("drop_en", {24'b0, entry_write_en_x}, 32'h0);
        chk("odd_op", {7'b0, entry_write_data}, 32'h100000A);
        cycle();

        // Enables drop mid-sequence: writes still issue.
        set_alloc(1'b0, 8'h77, 12'h777, 12'h888);
        cycle();
        alloc_vld = 1'b0; cp0_ifu_nsfe = 1'b0;
        cycle(); cycle(); cycle();
        cp0_ifu_nsfe = 1'b1;

        // Reset during WR_SF: no WR_BAR afterwards.
        set_alloc(1'b1, 8'h99, 12'h999, 12'hAAA);
        cycle();
        alloc_vld = 1'b0; cpurst_b = 1'b0;
        cycle();
        cpurst_b = 1'b1;
        #1 chk("rst_no_bar", {24'b0, entry_write_en_x}, 32'h0);
        cycle();

        // Randomised traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            cpurst_b       = ($urandom_range(0, 59) != 0);
            cp0_ifu_nsfe   = ($urandom_range(0, 3) != 0);
            sfp_vl_pred_en = ($urandom_range(0, 3) == 0);
            train_vld      = ($urandom_range(0, 2) == 0);
            alloc_vld      = ($urandom_range(0, 1) == 0);
            train_hit_idx  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            train_op       = 4'($urandom);
            train_type     = 1'($urandom);
            alloc_type     = 1'($urandom);
            alloc_hi_pc    = 8'($urandom);
            alloc_sf_pc    = 12'($urandom);
            alloc_bar_pc   = 12'($urandom);
            entry_cnt_all  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) entry_cnt_all = entry_cnt_all | 16'h5555;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
